// File: rtl/uart_bt_fifo.sv
// UART transceiver for the Bluetooth serial link: 16x oversampled baud tick, configurable
// frame format, glitch-rejecting receiver, first-word fall-through RX FIFO and sticky errors.
module uart_bt_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] dout,
  output logic                 avail,
  input  logic                 rd,
  input  logic                 clr_err,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_ovr
);

  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  // Odd parity makes the total count of ones (data plus parity bit) odd.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [DW-1:0]        div_r;
  logic                 tick_s;
  logic [1:0]           sync_r;
  logic                 rx_s;
  rx_state_t            rx_st_r;
  logic [3:0]           rx_tck_r;
  logic [3:0]           rx_bit_r;
  logic [DATA_BITS-1:0] rx_sh_r;
  logic                 push_r;
  logic                 fe_set_r;
  logic                 pe_set_r;
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wp_r;
  logic [PW-1:0]        rp_r;
  logic [CW-1:0]        cnt_r;
  logic                 pop_s;
  logic                 wr_s;
  logic                 ovr_set_s;
  tx_state_t            tx_st_r;
  logic [3:0]           tx_tck_r;
  logic [3:0]           tx_bit_r;
  logic [DATA_BITS-1:0] tx_sh_r;
  logic                 tx_par_r;
  logic                 tx_stop_r;

  assign tick_s    = (div_r == DIV_LAST);
  assign rx_s      = sync_r[1];
  assign avail     = (cnt_r != '0);
  assign pop_s     = rd && avail;
  assign wr_s      = push_r && ((cnt_r != FULL_CNT) || pop_s);
  assign ovr_set_s = push_r && (cnt_r == FULL_CNT) && !pop_s;

  // Free-running oversampling divider shared by both directions
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                div_r <= '0;
    else if (div_r == DIV_LAST) div_r <= '0;
    else                       div_r <= div_r + DW'(1);
  end

  // Two-flop synchroniser for the asynchronous rx pin
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) sync_r <= 2'b11;
    else        sync_r <= {sync_r[0], rx};
  end

  // Receive FSM; after a bad stop bit it waits for the line to return high
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_st_r  <= R_IDLE;
      rx_tck_r <= 4'd0;
      rx_bit_r <= 4'd0;
      rx_sh_r  <= '0;
      push_r   <= 1'b0;
      fe_set_r <= 1'b0;
      pe_set_r <= 1'b0;
    end else begin
      push_r   <= 1'b0;
      fe_set_r <= 1'b0;
      pe_set_r <= 1'b0;
      case (rx_st_r)
        R_IDLE: if (!rx_s) begin
          rx_tck_r <= 4'd0;
          rx_st_r  <= R_START;
        end
        R_START: if (tick_s) begin
          if (rx_tck_r == 4'd7) begin
            rx_tck_r <= 4'd0;
            rx_bit_r <= 4'd0;
            rx_st_r  <= rx_s ? R_IDLE : R_DATA;
          end else begin
            rx_tck_r <= rx_tck_r + 4'd1;
          end
        end
        R_DATA: if (tick_s) begin
          rx_tck_r <= rx_tck_r + 4'd1;
          if (rx_tck_r == 4'd15) begin
            rx_sh_r  <= {rx_s, rx_sh_r[DATA_BITS-1:1]};
            rx_bit_r <= rx_bit_r + 4'd1;
            if (rx_bit_r == BIT_LAST) rx_st_r <= (PARITY != 0) ? R_PAR : R_STOP;
          end
        end
        R_PAR: if (tick_s) begin
          rx_tck_r <= rx_tck_r + 4'd1;
          if (rx_tck_r == 4'd15) begin
            pe_set_r <= (rx_s != par_bit(rx_sh_r));
            rx_st_r  <= R_STOP;
          end
        end
        R_STOP: if (tick_s) begin
          rx_tck_r <= rx_tck_r + 4'd1;
          if (rx_tck_r == 4'd15) begin
            push_r   <= rx_s;
            fe_set_r <= !rx_s;
            rx_st_r  <= rx_s ? R_IDLE : R_WAIT;
          end
        end
        R_WAIT: if (rx_s) rx_st_r <= R_IDLE;
        default: rx_st_r <= R_IDLE;
      endcase
    end
  end

  // FIFO storage; when full, a same-cycle pop frees the slot being written
  always_ff @(posedge clk_in) begin
    if (wr_s) mem_r[wp_r] <= rx_sh_r;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wp_r  <= '0;
      rp_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (wr_s)  wp_r <= wp_r + PW'(1);
      if (pop_s) rp_r <= rp_r + PW'(1);
      case ({wr_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Head of FIFO, forced to zero when empty
  always_comb begin
    dout = '0;
    if (avail) dout = mem_r[rp_r];
    else       dout = '0;
  end

  // Sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      if (fe_set_r)     err_frame <= 1'b1;
      else if (clr_err) err_frame <= 1'b0;
      if (pe_set_r)     err_parity <= 1'b1;
      else if (clr_err) err_parity <= 1'b0;
      if (ovr_set_s)    err_ovr <= 1'b1;
      else if (clr_err) err_ovr <= 1'b0;
    end
  end

  // Transmit FSM with registered line, busy and done
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx_st_r   <= T_IDLE;
      tx_tck_r  <= 4'd0;
      tx_bit_r  <= 4'd0;
      tx_sh_r   <= '0;
      tx_par_r  <= 1'b0;
      tx_stop_r <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((tx_st_r != T_IDLE) && tick_s) tx_tck_r <= tx_tck_r + 4'd1;
      case (tx_st_r)
        T_IDLE: if (enable) begin
          tx_sh_r  <= din;
          tx_par_r <= par_bit(din);
          tx_tck_r <= 4'd0;
          busy     <= 1'b1;
          tx       <= 1'b0;
          tx_st_r  <= T_START;
        end
        T_START: if (tick_s && (tx_tck_r == 4'd15)) begin
          tx       <= tx_sh_r[0];
          tx_sh_r  <= tx_sh_r >> 1;
          tx_bit_r <= 4'd0;
          tx_st_r  <= T_DATA;
        end
        T_DATA: if (tick_s && (tx_tck_r == 4'd15)) begin
          if (tx_bit_r != BIT_LAST) begin
            tx       <= tx_sh_r[0];
            tx_sh_r  <= tx_sh_r >> 1;
            tx_bit_r <= tx_bit_r + 4'd1;
          end else if (PARITY != 0) begin
            tx      <= tx_par_r;
            tx_st_r <= T_PAR;
          end else begin
            tx        <= 1'b1;
            tx_stop_r <= 1'b0;
            tx_st_r   <= T_STOP;
          end
        end
        T_PAR: if (tick_s && (tx_tck_r == 4'd15)) begin
          tx        <= 1'b1;
          tx_stop_r <= 1'b0;
          tx_st_r   <= T_STOP;
        end
        T_STOP: if (tick_s && (tx_tck_r == 4'd15)) begin
          if (tx_stop_r == STOP_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            tx_st_r <= T_IDLE;
          end else begin
            tx_stop_r <= tx_stop_r + 1'b1;
          end
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          tx_st_r <= T_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bt_fifo.sv
// Self-checking bench for uart_bt_fifo: 8N1 instance plus an even-parity instance,
// DIV=4 so one bit is 64 clocks.
module tb_uart_bt_fifo;

  localparam int CLK_HZ = 640_000;
  localparam int BAUD   = 10_000;
  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx0, tx0, en0, busy0, done0, avail0, rd0, clr0, fe0, pe0, oe0;
  logic [7:0] din0, dout0;
  logic       rx1, tx1, en1, busy1, done1, avail1, rd1, clr1, fe1, pe1, oe1;
  logic [7:0] din1, dout1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_avail;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } rx_vec_t;
  rx_vec_t rx_vecs [5];

  always #5 clk = ~clk;

  uart_bt_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk_in(clk), .reset(reset_n), .rx(rx0), .tx(tx0), .din(din0), .enable(en0),
    .busy(busy0), .done(done0), .dout(dout0), .avail(avail0), .rd(rd0),
    .clr_err(clr0), .err_frame(fe0), .err_parity(pe0), .err_ovr(oe0));

  uart_bt_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_par (
    .clk_in(clk), .reset(reset_n), .rx(rx1), .tx(tx1), .din(din1), .enable(en1),
    .busy(busy1), .done(done1), .dout(dout1), .avail(avail1), .rd(rd1),
    .clr_err(clr1), .err_frame(fe1), .err_parity(pe1), .err_ovr(oe1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(inout int bc, inout int dc);
    @(negedge clk);
    if (busy0) bc++;
    if (done0) dc++;
  endtask

  // Drive a level on one of the rx lines for n clocks.
  task automatic rx_bit(input logic sel, input logic v, input int n);
    if (sel) rx1 = v;
    else     rx0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic sel, input logic [7:0] d, input logic use_par,
                         input logic pbit, input logic stop);
    rx_bit(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) rx_bit(sel, d[i], BIT_CLK);
    if (use_par) rx_bit(sel, pbit, BIT_CLK);
    rx_bit(sel, stop, BIT_CLK);
    rx_bit(sel, 1'b1, 8);
  endtask

  // Called at the first negedge after acceptance. The divider runs free, so the start
  // bit may be up to DIV-1 = 3 clocks short; samples are taken at bit centres.
  task automatic tx_frame_after_accept(input logic [7:0] d, input logic chk_len);
    int bc = 1;
    int dc = 0;
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    chk("tx_accept_busy", busy0, 1'b1);
    chk("tx_start_low", tx0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 31 : BIT_CLK) step(bc, dc);
      chk($sformatf("tx_bit%0d_%02h", k, d), tx0, f[k]);
    end
    for (int i = 0; i < 64 && dc == 0; i++) step(bc, dc);
    chk("tx_done_pulse", dc, 1);
    chk("tx_busy_at_done", busy0, 1'b0);
    if (chk_len) chk_range("tx_busy_len", bc, 637, 640);
  endtask

  task automatic tx_single(input logic [7:0] d);
    int bc = 0;
    int dc = 0;
    @(negedge clk); en0 = 1'b1; din0 = d;
    @(negedge clk); en0 = 1'b0; din0 = ~d;
    tx_frame_after_accept(d, 1'b1);
    repeat (20) step(bc, dc);
    chk("tx_done_once", dc, 0);
    chk("tx_idle_high", tx0, 1'b1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic       model_ovr;
    logic [7:0] d, d2;

    rx_vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    rx_vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    rx_vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    rx_vecs[3] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};
    rx_vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

    reset_n = 1'b0;
    rx0 = 1'b1; en0 = 1'b0; din0 = 8'h00; rd0 = 1'b0; clr0 = 1'b0;
    rx1 = 1'b1; en1 = 1'b0; din1 = 8'h00; rd1 = 1'b0; clr1 = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_avail", avail0, 1'b0);
    chk("rst_dout", dout0, 8'h00);
    chk("rst_ferr", fe0, 1'b0);
    chk("rst_perr", pe0, 1'b0);
    chk("rst_ovr", oe0, 1'b0);

    // TX: fixed pattern, random patterns, then back-to-back with enable held high
    tx_single(8'hA5);
    for (int i = 0; i < 2; i++) tx_single(8'($urandom));
    d = 8'($urandom); d2 = 8'($urandom);
    @(negedge clk); en0 = 1'b1; din0 = d;
    @(negedge clk); din0 = d2;
    tx_frame_after_accept(d, 1'b0);
    @(negedge clk); en0 = 1'b0;
    tx_frame_after_accept(d2, 1'b1);

    // RX: push latency around the stop-bit centre
    rx_bit(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) rx_bit(1'b0, d[i] & 1'b0 | (8'h3C >> i) & 8'h01, BIT_CLK);
    rx0 = 1'b1;
    repeat (24) @(negedge clk);
    chk("rx_avail_before_stop", avail0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_avail_after_stop", avail0, 1'b1);
    chk("rx_dout_3c", dout0, 8'h3C);
    rd0 = 1'b1; @(negedge clk); rd0 = 1'b0;
    chk("rx_avail_after_rd", avail0, 1'b0);

    // RX table
    for (int v = 0; v < 5; v++) begin
      send_rx(1'b0, rx_vecs[v].data, 1'b0, 1'b0, rx_vecs[v].stop);
      rx_bit(1'b0, 1'b1, 20);
      chk($sformatf("tbl%0d_avail", v), avail0, rx_vecs[v].exp_avail);
      chk($sformatf("tbl%0d_dout", v), dout0, rx_vecs[v].exp_dout);
      chk($sformatf("tbl%0d_ferr", v), fe0, rx_vecs[v].exp_ferr);
      chk($sformatf("tbl%0d_perr", v), pe0, 1'b0);
      clr0 = 1'b1; rd0 = 1'b1; @(negedge clk); clr0 = 1'b0; rd0 = 1'b0;
      chk($sformatf("tbl%0d_ferr_clr", v), fe0, 1'b0);
      chk($sformatf("tbl%0d_empty", v), avail0, 1'b0);
    end

    // Glitch shorter than half a bit
    rx_bit(1'b0, 1'b0, 20);
    rx_bit(1'b0, 1'b1, 700);
    chk("glitch_avail", avail0, 1'b0);
    chk("glitch_flags", {fe0, pe0, oe0}, 3'b000);

    // Overflow with random bytes and gaps, against a queue model
    model_ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      send_rx(1'b0, d, 1'b0, 1'b0, 1'b1);
      rx_bit(1'b0, 1'b1, int'($urandom_range(1, 40)));
      if (q.size() < 16) q.push_back(d);
      else model_ovr = 1'b1;
    end
    chk("ovr_flag", oe0, model_ovr);
    chk("ovr_avail", avail0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d = q.pop_front();
      chk($sformatf("ovr_pop%0d", i), dout0, d);
      rd0 = 1'b1; @(negedge clk); rd0 = 1'b0;
    end
    chk("ovr_drained", avail0, 1'b0);
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
    chk("ovr_clr", oe0, 1'b0);

    // Even parity instance: bad parity stored with flag, then good parity
    send_rx(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    rx_bit(1'b1, 1'b1, 20);
    chk("par_bad_avail", avail1, 1'b1);
    chk("par_bad_dout", dout1, 8'h01);
    chk("par_bad_flag", pe1, 1'b1);
    clr1 = 1'b1; rd1 = 1'b1; @(negedge clk); clr1 = 1'b0; rd1 = 1'b0;
    chk("par_clr", pe1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8'h03 : 8'($urandom);
      send_rx(1'b1, d, 1'b1, ^d, 1'b1);
      rx_bit(1'b1, 1'b1, 20);
      chk($sformatf("par_good%0d_dout", i), dout1, d);
      chk($sformatf("par_good%0d_flag", i), pe1, 1'b0);
      rd1 = 1'b1; @(negedge clk); rd1 = 1'b0;
    end

    // Reset in the middle of a TX frame with a byte waiting in the FIFO
    send_rx(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    rx_bit(1'b0, 1'b1, 20);
    chk("pre_reset_avail", avail0, 1'b1);
    @(negedge clk); en0 = 1'b1; din0 = 8'h00;
    @(negedge clk); en0 = 1'b0;
    repeat (200) @(negedge clk);
    chk("pre_reset_busy", busy0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_tx", tx0, 1'b1);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_avail", avail0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_tx", tx0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
